accel_offset_sum: RTL and testbench

- Parametrised successor to the fixed 8-channel offset-elimination and summing stage of the accelerometer pipeline.
- One instance handles one axis: it takes NCH packed signed DW-bit samples per frame, typically from the I2C capture block's per-frame flag.
- It runs an on-demand offset calibration (averages 2^CAL_LOG2 frames per channel), subtracts the stored offsets and sums all channels.
- The scaled, saturated result goes to the BCD, frame-sync and filter consumers.

---
 rtl/accel_offset_sum.sv | 176 +++++++++++++++++
 tb/tb_accel_offset_sum.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/accel_offset_sum.sv
// Per-axis offset removal and channel sum, offsets taken from an on-demand averaging calibration.
// Latency: out_valid NCH+1 cycles after in_valid; one channel per cycle through a single shared adder.
// No backpressure: a frame arriving while the engine is busy is dropped and flagged on overrun.
module accel_offset_sum #(
    parameter int NCH       = 8,
    parameter int DW        = 14,
    parameter int CAL_LOG2  = 4,
    parameter int DIV_SHIFT = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cal_start,
    input  logic                 in_valid,
    input  logic [NCH*DW-1:0]    in_data,
    output logic signed [DW-1:0] sum_data,
    output logic                 out_valid,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic                 sat_flag,
    output logic                 overrun
);
    localparam int CHW = $clog2(NCH);
    localparam int AW  = DW + 1 + $clog2(NCH);
    localparam int CW  = DW + CAL_LOG2;
    localparam int SW  = (AW > CW) ? AW : CW;
    localparam logic signed [AW-1:0] RES_MAX = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] RES_MIN = AW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {E_IDLE, E_LATCH, E_WALK, E_FINISH} eng_t;
    typedef enum logic {M_RUN, M_CAL} mode_t;

    eng_t                  eng_q, eng_d;
    mode_t                 mode_q, mode_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [CAL_LOG2-1:0]   cal_cnt_q;
    logic [NCH*DW-1:0]     frame_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [DW-1:0]  off_q  [NCH];
    logic signed [CW-1:0]  cacc_q [NCH];

    logic                  last_ch, accept, drop, walk_run, walk_cal, emit, cal_fin, cal_last;
    logic signed [DW-1:0]  in_sel, off_sel;
    logic signed [CW-1:0]  cacc_sel;
    logic signed [DW:0]    corr;
    logic signed [SW-1:0]  add_a, add_b, add_s;
    logic signed [AW-1:0]  acc_fin, res;
    logic signed [DW-1:0]  res_clip;
    logic                  res_sat;

    // State registers for the mode and engine FSMs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            eng_q  <= E_IDLE;
            mode_q <= M_RUN;
            ch_q   <= '0;
        end else begin
            eng_q  <= eng_d;
            mode_q <= mode_d;
            ch_q   <= ch_d;
        end
    end

    assign last_ch = (ch_q == CHW'(NCH - 1));

    // cal_start overrides everything: in-flight frame abandoned, calibration (re)started
    always_comb begin
        eng_d  = eng_q;
        ch_d   = ch_q;
        mode_d = mode_q;
        if (cal_start) begin
            eng_d  = E_IDLE;
            ch_d   = '0;
            mode_d = M_CAL;
        end else begin
            case (eng_q)
                E_IDLE:   if (in_valid) eng_d = E_LATCH;
                E_LATCH: begin
                    eng_d = E_WALK;
                    ch_d  = '0;
                end
                E_WALK: begin
                    if (last_ch) eng_d = E_FINISH;
                    else         ch_d  = ch_q + CHW'(1);
                end
                E_FINISH: eng_d = E_IDLE;
            endcase
            if (cal_last) mode_d = M_RUN;
        end
    end

    always_comb begin
        accept   = 1'b0;
        drop     = 1'b0;
        walk_run = 1'b0;
        walk_cal = 1'b0;
        emit     = 1'b0;
        cal_fin  = 1'b0;
        cal_last = 1'b0;
        if (!cal_start) begin
            accept   = (eng_q == E_IDLE) && in_valid;
            drop     = (eng_q != E_IDLE) && in_valid;
            walk_run = (eng_q == E_WALK) && (mode_q == M_RUN);
            walk_cal = (eng_q == E_WALK) && (mode_q == M_CAL);
            emit     = walk_run && last_ch;
            cal_fin  = (eng_q == E_FINISH) && (mode_q == M_CAL);
            cal_last = cal_fin && (cal_cnt_q == '1);
        end
    end

    assign cal_busy = (mode_q == M_CAL);

    assign in_sel   = frame_q[ch_q*DW +: DW];
    assign off_sel  = off_q[ch_q];
    assign cacc_sel = cacc_q[ch_q];
    assign corr     = {in_sel[DW-1], in_sel} - {off_sel[DW-1], off_sel};

    // One adder serves both the run-mode sum and the calibration accumulators
    always_comb begin
        if (mode_q == M_CAL) begin
            add_a = SW'(cacc_sel);
            add_b = SW'(in_sel);
        end else begin
            add_a = SW'(acc_q);
            add_b = SW'(corr);
        end
        add_s = add_a + add_b;
    end

    always_comb begin
        acc_fin  = add_s[AW-1:0];
        res      = acc_fin >>> DIV_SHIFT;
        res_sat  = (res > RES_MAX) || (res < RES_MIN);
        res_clip = res[DW-1:0];
        if (res > RES_MAX)      res_clip = RES_MAX[DW-1:0];
        else if (res < RES_MIN) res_clip = RES_MIN[DW-1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_q   <= '0;
            acc_q     <= '0;
            cal_cnt_q <= '0;
            sum_data  <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            cal_done  <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                off_q[k]  <= '0;
                cacc_q[k] <= '0;
            end
        end else begin
            out_valid <= emit;
            overrun   <= drop;
            if (accept)            frame_q <= in_data;
            if (eng_q == E_LATCH)  acc_q   <= '0;
            if (walk_run)          acc_q   <= add_s[AW-1:0];
            if (walk_cal)          cacc_q[ch_q] <= add_s[CW-1:0];
            if (emit) begin
                sum_data <= res_clip;
                sat_flag <= res_sat;
            end
            if (cal_start) begin
                cal_cnt_q <= '0;
                cal_done  <= 1'b0;
                for (int k = 0; k < NCH; k++) cacc_q[k] <= '0;
            end else if (cal_fin) begin
                cal_cnt_q <= cal_cnt_q + CAL_LOG2'(1);
                if (cal_last) begin
                    cal_done <= 1'b1;
                    for (int k = 0; k < NCH; k++) off_q[k] <= DW'(cacc_q[k] >>> CAL_LOG2);
                end
            end
        end
    end
endmodule

// File: tb/tb_accel_offset_sum.sv
// Directed bench for accel_offset_sum: default instance plus a DIV_SHIFT=0 instance sharing stimulus.
module tb_accel_offset_sum;
    localparam int NCH = 8;
    localparam int DW  = 14;
    localparam int FW  = NCH * DW;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic cal_start = 1'b0;
    logic in_valid = 1'b0;
    logic [FW-1:0] in_data = '0;
    logic signed [DW-1:0] sum_data, sum_data0;
    logic out_valid, cal_busy, cal_done, sat_flag, overrun;
    logic out_valid0, cal_busy0, cal_done0, sat_flag0, overrun0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    accel_offset_sum #(.NCH(NCH), .DW(DW), .CAL_LOG2(4), .DIV_SHIFT(3)) u_dut (
        .CLK(CLK), .RST(RST), .cal_start(cal_start), .in_valid(in_valid), .in_data(in_data),
        .sum_data(sum_data), .out_valid(out_valid), .cal_busy(cal_busy), .cal_done(cal_done),
        .sat_flag(sat_flag), .overrun(overrun)
    );

    accel_offset_sum #(.NCH(NCH), .DW(DW), .CAL_LOG2(4), .DIV_SHIFT(0)) u_dut_sat (
        .CLK(CLK), .RST(RST), .cal_start(cal_start), .in_valid(in_valid), .in_data(in_data),
        .sum_data(sum_data0), .out_valid(out_valid0), .cal_busy(cal_busy0), .cal_done(cal_done0),
        .sat_flag(sat_flag0), .overrun(overrun0)
    );

    typedef struct packed {
        logic [FW-1:0] dat;
        int            sum;
        int            sat;
        int            sum0;
        int            sat0;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] frm(input int base, input int step);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < NCH; k++) f[k*DW +: DW] = DW'(base + k * step);
        return f;
    endfunction

    function automatic logic [FW-1:0] frm_alt();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < NCH; k++) f[k*DW +: DW] = (k % 2 == 0) ? DW'(8191) : DW'(-8192);
        return f;
    endfunction

    // Sends one frame, then watches 21 cycles; observation i is taken after the i-th edge past in_valid
    task automatic run_frame(input logic [FW-1:0] d, input logic with_cal, input int ovr_at,
                             input int cal_at, output int lat, output int nov, output int novr);
        @(negedge CLK);
        in_data   = d;
        in_valid  = 1'b1;
        cal_start = with_cal;
        @(negedge CLK);
        in_valid  = 1'b0;
        cal_start = 1'b0;
        lat = -1;
        nov = 0;
        novr = 0;
        for (int i = 0; i <= 20; i++) begin
            if (out_valid) begin
                nov++;
                if (lat < 0) lat = i;
            end
            if (overrun) novr++;
            in_valid  = (i == ovr_at);
            cal_start = (i == cal_at);
            if (i == ovr_at) in_data = ~d;
            @(negedge CLK);
        end
        in_valid  = 1'b0;
        cal_start = 1'b0;
    endtask

    task automatic pulse_cal();
        @(negedge CLK);
        cal_start = 1'b1;
        @(negedge CLK);
        cal_start = 1'b0;
    endtask

    initial begin
        int lat, nov, novr, tot;
        vec_t vecs [7];

        vecs[0] = '{dat: frm(100, 0),     sum: 100,   sat: 0, sum0: 800,   sat0: 0};
        vecs[1] = '{dat: frm(-8, 1),      sum: -5,    sat: 0, sum0: -36,   sat0: 0};
        vecs[2] = '{dat: frm(8191, 0),    sum: 8191,  sat: 0, sum0: 8191,  sat0: 1};
        vecs[3] = '{dat: frm(-8192, 0),   sum: -8192, sat: 0, sum0: -8192, sat0: 1};
        vecs[4] = '{dat: frm(0, 0),       sum: 0,     sat: 0, sum0: 0,     sat0: 0};
        vecs[5] = '{dat: frm(0, 1000),    sum: 3500,  sat: 0, sum0: 8191,  sat0: 1};
        vecs[6] = '{dat: frm_alt(),       sum: -1,    sat: 0, sum0: -4,    sat0: 0};

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_sum", sum_data, 0);
        check("rst_sum0", sum_data0, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cal_busy", cal_busy, 0);
        check("rst_cal_done", cal_done, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_overrun", overrun, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Uncalibrated table: offsets are zero
        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].dat, 1'b0, -1, -1, lat, nov, novr);
            check($sformatf("v%0d_latency", v), lat, 9);
            check($sformatf("v%0d_nvalid", v), nov, 1);
            check($sformatf("v%0d_novr", v), novr, 0);
            check($sformatf("v%0d_sum", v), sum_data, vecs[v].sum);
            check($sformatf("v%0d_sat", v), sat_flag, vecs[v].sat);
            check($sformatf("v%0d_sum0", v), sum_data0, vecs[v].sum0);
            check($sformatf("v%0d_sat0", v), sat_flag0, vecs[v].sat0);
        end

        // Overrun: second frame 3 cycles after the first is dropped
        run_frame(frm(100, 0), 1'b0, 2, -1, lat, nov, novr);
        check("ovr_novr", novr, 1);
        check("ovr_nvalid", nov, 1);
        check("ovr_latency", lat, 9);
        check("ovr_sum", sum_data, 100);
        check("ovr_sum0", sum_data0, 800);

        // Calibration on 16 frames of 50
        pulse_cal();
        check("cal_busy_start", cal_busy, 1);
        tot = 0;
        for (int f = 0; f < 16; f++) begin
            run_frame(frm(50, 0), 1'b0, -1, -1, lat, nov, novr);
            tot += nov;
            if (f == 14) begin
                check("cal15_busy", cal_busy, 1);
                check("cal15_done", cal_done, 0);
            end
        end
        check("cal_nvalid", tot, 0);
        check("cal_held_sum", sum_data, 100);
        check("cal_done", cal_done, 1);
        check("cal_busy_end", cal_busy, 0);
        run_frame(frm(150, 0), 1'b0, -1, -1, lat, nov, novr);
        check("postcal_sum", sum_data, 100);
        check("postcal_sum0", sum_data0, 800);
        check("postcal_nvalid", nov, 1);

        // cal_start together with in_valid: frame ignored, calibration begins
        run_frame(frm(77, 0), 1'b1, -1, -1, lat, nov, novr);
        check("coll_nvalid", nov, 0);
        check("coll_novr", novr, 0);
        check("coll_busy", cal_busy, 1);
        check("coll_done", cal_done, 0);

        // Restart after 10 frames: 16 fresh frames needed
        for (int f = 0; f < 10; f++) run_frame(frm(20, 0), 1'b0, -1, -1, lat, nov, novr);
        pulse_cal();
        for (int f = 0; f < 16; f++) begin
            run_frame(frm(-30, 0), 1'b0, -1, -1, lat, nov, novr);
            if (f == 14) begin
                check("rst_cal15_busy", cal_busy, 1);
                check("rst_cal15_done", cal_done, 0);
            end
        end
        check("restart_done", cal_done, 1);
        check("restart_busy", cal_busy, 0);
        run_frame(frm(10, 0), 1'b0, -1, -1, lat, nov, novr);
        check("restart_sum", sum_data, 40);
        check("restart_sum0", sum_data0, 320);

        // cal_start mid-walk aborts the frame
        run_frame(frm(100, 0), 1'b0, -1, 4, lat, nov, novr);
        check("abort_nvalid", nov, 0);
        check("abort_busy", cal_busy, 1);
        check("abort_sum", sum_data, 40);

        // Reset during calibration frame 7
        for (int f = 0; f < 6; f++) run_frame(frm(40, 0), 1'b0, -1, -1, lat, nov, novr);
        @(negedge CLK);
        in_data  = frm(40, 0);
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("prerst_busy", cal_busy, 1);
        RST = 1'b0;
        #1;
        check("midrst_sum", sum_data, 0);
        check("midrst_busy", cal_busy, 0);
        check("midrst_sum0", sum_data0, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        run_frame(frm(150, 0), 1'b0, -1, -1, lat, nov, novr);
        check("postrst_latency", lat, 9);
        check("postrst_sum", sum_data, 150);
        check("postrst_sum0", sum_data0, 1200);
        check("postrst_done", cal_done, 0);
        check("postrst_busy", cal_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
